// File: rtl/lst1_pkg.sv
// Shared definitions for the LST-1 PE sequencing logic.
//   seq_state_t : sequencer FSM states
//   PE_ADDR_W   : width of the PE ROM address bus
//   fx_width()  : total fixed-point word width from integer/fraction bits
package lst1_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } seq_state_t;

    localparam int PE_ADDR_W = 5;

    function automatic int fx_width(input int int_bits, input int frc_bits);
        return int_bits + frc_bits;
    endfunction

endpackage

// File: rtl/pe_rc_sequencer.sv
// Sequencer for one PE_rc processing element.
// Issues init/en/address/rc_sel to the PE, streams operands from an upstream
// valid/ready source into it, and returns the finished MAC result on a
// valid/ready output.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, sel          begin one result; sel picks row (0) / column (1) ROM
//   s_valid/s_ready/s_data   operand stream in
//   pe_init, pe_en, pe_addr, pe_rc_sel, pe_din   drive the PE
//   pe_dout             PE result
//   m_valid/m_ready/m_data   result stream out
//   busy                high whenever the FSM is not in IDLE
//   dbg_state           current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid and data stable until that edge;
// valid never depends combinationally on ready.
module pe_rc_sequencer
    import lst1_pkg::*;
#(
    parameter int INT_BITS = 5,
    parameter int FRC_BITS = 7,
    parameter int LEN      = 20,
    parameter int ROM_LAT  = 1,
    parameter int MAC_LAT  = 2,
    localparam int W       = fx_width(INT_BITS, FRC_BITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sel,
    input  logic                 s_valid,
    input  logic [W-1:0]         s_data,
    output logic                 s_ready,
    output logic                 pe_init,
    output logic                 pe_en,
    output logic [PE_ADDR_W-1:0] pe_addr,
    output logic                 pe_rc_sel,
    output logic [W-1:0]         pe_din,
    input  logic [W-1:0]         pe_dout,
    output logic                 m_valid,
    output logic [W-1:0]         m_data,
    input  logic                 m_ready,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    generate
        if (LEN < 1 || LEN > 31) begin : g_len_check
            $error("pe_rc_sequencer: LEN must be in 1..31");
        end
        if (ROM_LAT < 1) begin : g_lat_check
            $error("pe_rc_sequencer: ROM_LAT must be at least 1");
        end
    endgenerate

    localparam int DRAIN_CYC = ROM_LAT + MAC_LAT;
    localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);
    localparam logic [PE_ADDR_W-1:0] K_LAST    = PE_ADDR_W'(LEN - 1);
    localparam logic [DCNT_W-1:0]    DCNT_LAST = DCNT_W'(DRAIN_CYC - 1);

    seq_state_t           state, state_nxt;
    logic [PE_ADDR_W-1:0] k;
    logic [DCNT_W-1:0]    dcnt;
    logic                 rc_sel_q;
    logic [W-1:0]         m_data_q;
    // Skew chain: delays en/din so din meets the ROM word addressed by k.
    logic [ROM_LAT-1:0]   en_sk;
    logic [W-1:0]         din_sk [ROM_LAT];

    logic s_hs;
    logic last_hs;
    logic drain_done;

    assign s_hs       = (state == RUN) && s_valid;
    assign last_hs    = s_hs && (k == K_LAST);
    assign drain_done = (state == DRAIN) && (dcnt == DCNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)      state_nxt = INIT;
            INIT:                    state_nxt = RUN;
            RUN:     if (last_hs)    state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = OUT;
            OUT:     if (m_ready)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Datapath registers: operand counter, drain counter, latched select,
    // result capture and the ROM-latency skew chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            dcnt     <= '0;
            rc_sel_q <= 1'b0;
            m_data_q <= '0;
            en_sk    <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                din_sk[i] <= '0;
            end
        end else begin
            if (state == IDLE && start) begin
                rc_sel_q <= sel;
                k        <= '0;
            end else if (s_hs && !last_hs) begin
                k <= k + PE_ADDR_W'(1);
            end

            if (last_hs) begin
                dcnt <= '0;
            end else if (state == DRAIN && !drain_done) begin
                dcnt <= dcnt + DCNT_W'(1);
            end

            if (drain_done) begin
                m_data_q <= pe_dout;
            end

            en_sk[0]  <= s_hs;
            din_sk[0] <= s_hs ? s_data : '0;
            for (int i = 1; i < ROM_LAT; i++) begin
                en_sk[i]  <= en_sk[i-1];
                din_sk[i] <= din_sk[i-1];
            end
        end
    end

    // Outputs
    always_comb begin
        s_ready   = (state == RUN);
        pe_init   = (state == INIT);
        pe_en     = en_sk[ROM_LAT-1];
        pe_din    = din_sk[ROM_LAT-1];
        pe_addr   = (state == RUN) ? k : '0;
        pe_rc_sel = rc_sel_q;
        m_valid   = (state == OUT);
        m_data    = m_data_q;
        busy      = (state != IDLE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_pe_rc_sequencer.sv
module tb_pe_rc_sequencer;
  import lst1_pkg::*;

  localparam int INT_BITS = 5;
  localparam int FRC_BITS = 7;
  localparam int W        = INT_BITS + FRC_BITS;
  localparam int LEN      = 4;
  localparam int ROM_LAT  = 1;
  localparam int MAC_LAT  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         start = 0, sel = 0, s_valid = 0, m_ready = 0;
  logic [W-1:0] s_data = '0;
  logic         s_ready, pe_init, pe_en, pe_rc_sel, m_valid, busy;
  logic [4:0]   pe_addr;
  logic [W-1:0] pe_din, pe_dout, m_data;
  logic [2:0]   dbg_state;

  pe_rc_sequencer #(
    .INT_BITS(INT_BITS), .FRC_BITS(FRC_BITS), .LEN(LEN),
    .ROM_LAT(ROM_LAT), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .pe_init(pe_init), .pe_en(pe_en), .pe_addr(pe_addr),
    .pe_rc_sel(pe_rc_sel), .pe_din(pe_din), .pe_dout(pe_dout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- PE stand-in ----------------
  logic [W-1:0] rom_row [33];
  logic [W-1:0] rom_col [33];
  logic [W-1:0] rom_q = '0;
  logic [W-1:0] acc_m = '0;
  logic [W-1:0] dout_r = '0;
  assign pe_dout = dout_r;

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  always @(posedge clk) begin
    int idx;
    idx = int'(pe_addr) + 1;
    rom_q <= pe_rc_sel ? rom_col[idx] : rom_row[idx];
    if (pe_init)
      acc_m <= pe_rc_sel ? rom_col[0] : rom_row[0];
    else if (pe_en)
      acc_m <= acc_m + W'((sx(pe_din) * sx(rom_q)) >>> FRC_BITS);
    dout_r <= acc_m;
  end

  // ---------------- reference model ----------------
  logic [W-1:0] ops [LEN];
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] ref_result(input logic s);
    int acc;
    acc = s ? sx(rom_col[0]) : sx(rom_row[0]);
    for (int i = 0; i < LEN; i++)
      acc += (sx(ops[i]) * (s ? sx(rom_col[i+1]) : sx(rom_row[i+1]))) >>> FRC_BITS;
    return W'(acc);
  endfunction

  // ---------------- continuous monitor ----------------
  logic         cur_sel = 0;
  logic         hs_d = 0;
  logic [W-1:0] din_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_d  = 0;
      din_d = '0;
    end else begin
      check_eq("pe_en_skew", pe_en, hs_d);
      if (hs_d) check_eq("pe_din_skew", pe_din, din_d);
      check_eq("init_en_excl", pe_init & pe_en, 0);
      if (busy) check_eq("rc_sel_hold", pe_rc_sel, cur_sel);
      hs_d  = s_valid && s_ready;
      din_d = s_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit check_outs);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    if (check_outs) begin
      check_eq("rst_busy", busy, 0);
      check_eq("rst_state", dbg_state, 32'(IDLE));
      check_eq("rst_s_ready", s_ready, 0);
      check_eq("rst_pe_init", pe_init, 0);
      check_eq("rst_pe_en", pe_en, 0);
      check_eq("rst_pe_addr", pe_addr, 0);
      check_eq("rst_pe_rc_sel", pe_rc_sel, 0);
      check_eq("rst_pe_din", pe_din, 0);
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_data", m_data, 0);
    end
    start = 0; s_valid = 0; m_ready = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic do_op(input logic sel_v, input int stall_n, input int wait_n,
                       input bit toggle_sel, input bit hold_out, input bit chained,
                       input int abort_at);
    logic [W-1:0] exp_v;
    logic [W-1:0] got_exp;
    int lat;
    bit seen;
    exp_v = ref_result(sel_v);
    exp_q.push_back(exp_v);

    if (!chained) begin
      @(posedge clk); #1;
      start = 1; sel = sel_v; m_ready = 0;
      @(negedge clk);
      check_eq("start_idle_busy", busy, 0);
    end
    @(posedge clk); #1;
    start = 0; cur_sel = sel_v;
    @(negedge clk);
    check_eq("init_pulse", pe_init, 1);
    check_eq("init_addr", pe_addr, 0);
    check_eq("init_busy", busy, 1);
    check_eq("init_s_ready", s_ready, 0);

    for (int i = 0; i < LEN; i++) begin
      if (i == abort_at) begin
        do_reset(1);
        void'(exp_q.pop_back());
        return;
      end
      if (i == 2) begin
        for (int s = 0; s < stall_n; s++) begin
          @(posedge clk); #1;
          s_valid = 0; s_data = W'($urandom);
          if (toggle_sel) sel = 1'($urandom_range(0, 1));
          @(negedge clk);
          check_eq("stall_addr", pe_addr, 2);
          check_eq("stall_s_ready", s_ready, 1);
        end
      end
      @(posedge clk); #1;
      s_valid = 1; s_data = ops[i];
      if (toggle_sel) sel = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("run_addr", pe_addr, i);
      check_eq("run_s_ready", s_ready, 1);
    end
    @(posedge clk); #1;
    s_valid = 0; s_data = W'($urandom);

    lat = 1; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("drain_s_ready", s_ready, 0);
      if (m_valid) seen = 1;
      else lat++;
    end
    check_eq("m_valid_timeout", seen, 1);
    if (!seen) begin
      void'(exp_q.pop_back());
      do_reset(0);
      return;
    end
    check_eq("m_valid_latency", lat, ROM_LAT + MAC_LAT + 1);

    for (int w = 0; w < wait_n; w++) begin
      check_eq("out_valid_hold", m_valid, 1);
      check_eq("out_data_hold", m_data, exp_v);
      check_eq("out_busy", busy, 1);
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    @(posedge clk); #1;
    m_ready = 1; start = hold_out; sel = sel_v;
    @(negedge clk);
    check_eq("out_valid", m_valid, 1);
    if (m_valid && m_ready && exp_q.size() > 0) begin
      got_exp = exp_q.pop_front();
      check_eq("sb_result", m_data, got_exp);
    end
    @(posedge clk); #1;
    m_ready = 0; start = hold_out; sel = sel_v;
    @(negedge clk);
    check_eq("post_valid", m_valid, 0);
    check_eq("post_idle_busy", busy, 0);
  endtask

  task automatic load_random_ops();
    for (int i = 0; i < LEN; i++) ops[i] = W'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 33; i++) begin
      rom_row[i] = W'($urandom);
      rom_col[i] = W'($urandom);
    end
    #1 rst_n = 0;
    @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_m_valid", m_valid, 0);
    check_eq("reset_m_data", m_data, 0);
    check_eq("reset_pe_din", pe_din, 0);
    check_eq("reset_pe_init", pe_init, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1;

    // 1: directed operands back to back
    ops[0] = 12'h080; ops[1] = 12'h100; ops[2] = 12'h040; ops[3] = 12'hF80;
    do_op(0, 0, 0, 0, 0, 0, -1);
    // 2: same operands with a 3-cycle stall after the second
    do_op(0, 3, 0, 0, 0, 0, -1);
    // 3: consumer stalls 5 cycles, start pulses meanwhile
    do_op(0, 0, 5, 0, 0, 0, -1);
    // 4: reset in RUN with k=2, then a clean operation
    load_random_ops();
    do_op(0, 0, 0, 0, 0, 0, 2);
    do_op(1, 0, 1, 0, 0, 0, -1);
    // 5: sel=1, sel toggles during RUN
    load_random_ops();
    do_op(1, 2, 0, 1, 0, 0, -1);
    // 6: start held across the OUT handshake
    load_random_ops();
    do_op(0, 0, 2, 0, 1, 0, -1);
    load_random_ops();
    do_op(0, 1, 0, 0, 0, 1, -1);

    // randomized operations
    for (int t = 0; t < 12; t++) begin
      load_random_ops();
      do_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4),
            1'($urandom_range(0, 1)), 0, 0, -1);
    end

    check_eq("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
